// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - Button conditioning, mode FSM, increment strobes and run tick for the clock
// Optional feature macro: CLK_AUTO_REPEAT_EN (auto-repeat of a held increment button in SET modes).
module clock_mode_ctrl #(
    parameter int TICK_DIV      = 10000000,
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       soft_rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       tick,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour,
    output logic       clr,
    output logic [1:0] mode,
    output logic       mode_led
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } mode_e;

    // Synchronizer bit order: [0]=soft_rst, [1]=mode_btn, [2]=inc_btn
    logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic             clr_w;
    logic [1:0]       btn_s;

    // Debouncer index: [0]=mode, [1]=inc
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];
    logic [1:0]       deb_lvl_q, deb_lvl_d;
    logic [1:0]       deb_dly_q, deb_dly_d;
    logic             mode_press, inc_press;

    mode_e            state_q, state_d;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic [2:0]       inc_q, inc_d;
    logic             run_stay, inc_fire, rpt_fire;

    always_comb begin
        sync1_d = {inc_btn, mode_btn, soft_rst};
        sync2_d = sync1_q;
    end

    assign clr_w = sync2_q[0];
    assign btn_s = sync2_q[2:1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            deb_lvl_d[i] = deb_lvl_q[i];
            if (clr_w) begin
                deb_lvl_d[i] = 1'b0;
            end else if (btn_s[i] != deb_lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_lvl_d[i] = btn_s[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        deb_dly_d = clr_w ? 2'b00 : deb_lvl_q;
    end

    assign mode_press = deb_lvl_q[0] & ~deb_dly_q[0];
    assign inc_press  = deb_lvl_q[1] & ~deb_dly_q[1];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_w) begin
            state_d = RUN;
        end else if (mode_press) begin
            case (state_q)
                RUN:      state_d = SET_SEC;
                SET_SEC:  state_d = SET_MIN;
                SET_MIN:  state_d = SET_HOUR;
                default:  state_d = RUN;
            endcase
        end
    end

    always_comb begin
        mode = state_q;
        if (clr_w) begin
            mode = 2'd0;
        end
        mode_led = (mode != 2'd0);
    end

`ifdef CLK_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_arm_q, rpt_arm_d;
    logic             rpt_first_q, rpt_first_d;
    logic             rpt_hold;

    // Counter value 1 marks the cycle after a strobe; it fires when it reaches the active interval.
    always_comb begin
        rpt_hold    = !clr_w && (state_q != RUN) && deb_lvl_q[1] && !mode_press;
        rpt_fire    = rpt_hold && rpt_arm_q && !inc_press &&
                      (rpt_cnt_q == (rpt_first_q ? RPT_DLY : RPT_PER));
        rpt_cnt_d   = '0;
        rpt_arm_d   = 1'b0;
        rpt_first_d = 1'b1;
        if (rpt_hold) begin
            if (inc_press) begin
                rpt_arm_d = 1'b1;
                rpt_cnt_d = RPT_W'(1);
            end else if (rpt_arm_q) begin
                rpt_arm_d   = 1'b1;
                rpt_first_d = rpt_first_q && !rpt_fire;
                rpt_cnt_d   = rpt_fire ? RPT_W'(1) : rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rpt_cnt_q   <= '0;
            rpt_arm_q   <= 1'b0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_arm_q   <= rpt_arm_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    localparam bit RPT_CFG = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);
    assign rpt_fire = RPT_CFG && 1'b0;
`endif

    // Leaving RUN also clears the prescaler so re-entry always waits a full TICK_DIV.
    always_comb begin
        run_stay = !clr_w && (state_q == RUN) && !mode_press;
        pre_d    = '0;
        tick_d   = 1'b0;
        if (run_stay) begin
            if (pre_q == PRE_LAST) begin
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
        inc_fire = !clr_w && (inc_press || rpt_fire);
        inc_d    = 3'b000;
        if (inc_fire) begin
            case (state_q)
                SET_SEC:  inc_d = 3'b001;
                SET_MIN:  inc_d = 3'b010;
                SET_HOUR: inc_d = 3'b100;
                default:  inc_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            deb_lvl_q    <= '0;
            deb_dly_q    <= '0;
            pre_q        <= '0;
            tick_q       <= 1'b0;
            inc_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_cnt_q[0] <= deb_cnt_d[0];
            deb_cnt_q[1] <= deb_cnt_d[1];
            deb_lvl_q    <= deb_lvl_d;
            deb_dly_q    <= deb_dly_d;
            pre_q        <= pre_d;
            tick_q       <= tick_d;
            inc_q        <= inc_d;
        end
    end

    assign tick     = tick_q;
    assign inc_sec  = inc_q[0];
    assign inc_min  = inc_q[1];
    assign inc_hour = inc_q[2];
    assign clr      = clr_w;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - Self-checking bench for clock_mode_ctrl
module tb_clock_mode_ctrl;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       soft_rst = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       tick, inc_sec, inc_min, inc_hour, clr, mode_led;
    logic [1:0] mode;

    clock_mode_ctrl #(
        .TICK_DIV     (8),
        .DEB_CYCLES   (4),
        .REPEAT_DELAY (16),
        .REPEAT_PERIOD(8)
    ) dut (
        .clock   (clock),
        .resetb  (resetb),
        .soft_rst(soft_rst),
        .mode_btn(mode_btn),
        .inc_btn (inc_btn),
        .tick    (tick),
        .inc_sec (inc_sec),
        .inc_min (inc_min),
        .inc_hour(inc_hour),
        .clr     (clr),
        .mode    (mode),
        .mode_led(mode_led)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int tick_in_set = 0;
    logic [1:0] m_mode = 2'd0;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0] mode;
        logic       do_mode;
        int         kind;
        logic [1:0] nmode;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Strobe scoreboard: every inc_* pulse must match the oldest expected {cycle, kind}.
    always @(negedge clock) begin : mon
        exp_t e;
        int   kind;
        if (resetb && tick && mode != 2'd0) tick_in_set++;
        if (resetb && (inc_sec || inc_min || inc_hour)) begin
            check("inc_onehot", int'(inc_sec) + int'(inc_min) + int'(inc_hour), 1);
            kind = inc_sec ? 1 : (inc_min ? 2 : 3);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: actual kind=%0d required none at cycle %0d", kind, cyc);
            end else begin
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_kind", kind, e.kind);
            end
        end
    end

    task automatic press(input logic do_mode, input logic do_inc, input int hold,
                         input int exp_kind, input logic [1:0] exp_mode, input int n_rep);
        int c;
        @(negedge clock);
        c = cyc;
        mode_btn = do_mode;
        inc_btn  = do_inc;
        if (exp_kind != 0) sb.push_back('{c + 7, exp_kind});
        if (n_rep > 0) begin
`ifdef CLK_AUTO_REPEAT_EN
            for (int r = 0; r < n_rep; r++) sb.push_back('{c + 7 + 16 + 8 * r, exp_kind});
`endif
        end
        for (int k = 1; k <= hold + 12; k++) begin
            @(negedge clock);
            if (k == hold) begin
                mode_btn = 1'b0;
                inc_btn  = 1'b0;
            end
            if (cyc == c + 6) check("mode_hold", mode, m_mode);
            if (cyc == c + 7) begin
                check("mode_next", mode, exp_mode);
                check("mode_led", mode_led, exp_mode != 2'd0);
            end
        end
        m_mode = exp_mode;
    endtask

    task automatic goto_mode(input logic [1:0] target);
        for (int n = 0; n < 4 && m_mode != target; n++) press(1'b1, 1'b0, 8, 0, 2'(m_mode + 2'd1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        vecs[0] = '{2'd1, 1'b0, 1, 2'd1};
        vecs[1] = '{2'd2, 1'b0, 2, 2'd2};
        vecs[2] = '{2'd3, 1'b0, 3, 2'd3};
        vecs[3] = '{2'd0, 1'b0, 0, 2'd0};
        vecs[4] = '{2'd2, 1'b1, 2, 2'd3};
        vecs[5] = '{2'd0, 1'b1, 0, 2'd1};
        vecs[6] = '{2'd3, 1'b1, 3, 2'd0};
        vecs[7] = '{2'd1, 1'b1, 1, 2'd2};

        // Power-up reset and free-running tick
        repeat (3) @(negedge clock);
        check("rst_mode", mode, 0);
        check("rst_led", mode_led, 0);
        check("rst_clr", clr, 0);
        check("rst_tick", tick, 0);
        check("rst_inc", {inc_sec, inc_min, inc_hour}, 0);
        resetb = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clock);
            check("tick_run", tick, (k % 8) == 0);
        end

        // Short glitch rejected, long press gives one strobe
        goto_mode(2'd1);
        press(1'b0, 1'b1, 3, 0, 2'd1, 0);
        press(1'b0, 1'b1, 12, 1, 2'd1, 0);

        // Full mode cycle; first tick a full period after re-entering RUN
        goto_mode(2'd0);
        for (int n = 0; n < 3; n++) press(1'b1, 1'b0, 8, 0, 2'(m_mode + 2'd1), 0);
        @(negedge clock);
        c = cyc;
        mode_btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 8) mode_btn = 1'b0;
            if (k == 6) check("wrap_hold", mode, 3);
            if (k == 7) begin
                check("wrap_mode", mode, 0);
                check("wrap_led", mode_led, 0);
            end
            if (k >= 8 && k <= 15) check("tick_reentry", tick, k == 15);
        end
        m_mode = 2'd0;

        // Table: increment per mode, alone and together with a mode press
        for (int i = 0; i < 8; i++) begin
            goto_mode(vecs[i].mode);
            press(vecs[i].do_mode, 1'b1, 8, vecs[i].kind, vecs[i].nmode, 0);
        end

        // Soft reset in SET_HOUR; presses begun during clr are discarded
        goto_mode(2'd3);
        @(negedge clock);
        c = cyc;
        soft_rst = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            if (k == 1) mode_btn = 1'b1;
            if (k == 2) inc_btn = 1'b1;
            if (k == 3) soft_rst = 1'b0;
            if (k == 6) mode_btn = 1'b0;
            if (k == 14) inc_btn = 1'b0;
            if (k <= 7) check("clr_level", clr, k >= 2 && k <= 4);
            if (k == 2) begin
                check("clr_mode", mode, 0);
                check("clr_led", mode_led, 0);
            end
        end
        check("mode_after_clr", mode, 0);
        m_mode = 2'd0;

        // Held increment: auto-repeat when enabled, single strobe otherwise
        goto_mode(2'd1);
        press(1'b0, 1'b1, 37, 1, 2'd1, 3);

        // Hardware reset mid-operation
        goto_mode(2'd2);
        @(negedge clock);
        resetb = 1'b0;
        #1;
        check("hwrst_mode", mode, 0);
        check("hwrst_led", mode_led, 0);
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        m_mode = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            check("tick_after_hwrst", tick, k == 8);
        end

        repeat (4) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        check("tick_in_set", tick_in_set, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
